// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-side memory controller.
package dmem_pkg;

  // Controller state for RAM transactions
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

  // Word offsets inside the 16-byte MMIO window
  localparam logic [3:0] CNT_OFS = 4'h0;
  localparam logic [3:0] DBG_OFS = 4'h4;

  // Data returned to the CPU when a transaction is abandoned on timeout
  localparam logic [31:0] BUS_ERR_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/dmem_mmio_regs.sv
// MMIO register block: free-running cycle counter, debug output register
// with a one-cycle valid strobe, and the MMIO read multiplexer.
module dmem_mmio_regs
  import dmem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_sel,
  input  logic [3:0]  ofs,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [31:0] debug_out,
  output logic        debug_valid
);

  logic [31:0] cycle_cnt;
  logic        dbg_wr;

  // A store only lands in debug_out when it targets the debug offset
  assign dbg_wr = wr_sel && (ofs == DBG_OFS);

  // Cycle counter advances every clock and wraps naturally at 2^32
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
    end
  end

  // Debug register captures store data; valid pulses for exactly one cycle per write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      debug_out   <= '0;
      debug_valid <= 1'b0;
    end else begin
      debug_valid <= dbg_wr;
      if (dbg_wr) begin
        debug_out <= wdata;
      end
    end
  end

  // Read mux: unmapped offsets inside the window read as zero
  always_comb begin
    rdata = '0;
    case (ofs)
      CNT_OFS: rdata = cycle_cnt;
      DBG_OFS: rdata = debug_out;
      default: rdata = '0;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data memory controller: converts CPU load/store strobes into a req/ack
// handshake to variable-latency memory, stalling the CPU meanwhile, and
// serves a small non-stalling MMIO window.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int          TIMEOUT   = 64,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_mem_rd,
  input  logic        cpu_mem_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] debug_out,
  output logic        debug_valid,
  output logic        align_err,
  output logic        bus_err
);

  localparam int WAIT_W = $clog2(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  dmem_state_t       state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [31:0]       rdata_q;
  logic [31:0]       mmio_rdata;

  logic access;
  logic misaligned;
  logic is_mmio;
  logic ram_access;
  logic mmio_load;
  logic mmio_store;

  // Address decode; a simultaneous rd+we is handled as a store
  assign access     = cpu_mem_rd || cpu_mem_we;
  assign misaligned = (cpu_addr[1:0] != 2'b00);
  assign is_mmio    = (cpu_addr[31:4] == MMIO_BASE[31:4]);
  assign ram_access = access && !misaligned && !is_mmio;
  assign mmio_load  = (state == IDLE) && cpu_mem_rd && !cpu_mem_we && !misaligned && is_mmio;
  assign mmio_store = (state == IDLE) && cpu_mem_we && !misaligned && is_mmio;

  dmem_mmio_regs u_mmio (
    .clk         (clk),
    .reset       (reset),
    .wr_sel      (mmio_store),
    .ofs         (cpu_addr[3:0]),
    .wdata       (cpu_wdata),
    .rdata       (mmio_rdata),
    .debug_out   (debug_out),
    .debug_valid (debug_valid)
  );

  // Transaction FSM with registered memory-side outputs, timeout and sticky error flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata_q   <= '0;
      align_err <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      if (access && misaligned) begin
        align_err <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (ram_access) begin
            mem_req   <= 1'b1;
            mem_we    <= cpu_mem_we;
            mem_addr  <= {cpu_addr[31:2], 2'b00};
            mem_wdata <= cpu_wdata;
            wait_cnt  <= '0;
            state     <= REQ;
          end
        end
        REQ: begin
          if (mem_ack) begin
            rdata_q <= mem_rdata;
            mem_req <= 1'b0;
            state   <= DONE;
          end else if (wait_cnt == WAIT_LAST) begin
            rdata_q <= BUS_ERR_DATA;
            mem_req <= 1'b0;
            bus_err <= 1'b1;
            state   <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          mem_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  // Stall and load-data return are decided combinationally from state and CPU inputs
  always_comb begin
    cpu_stall = 1'b0;
    cpu_rdata = '0;
    case (state)
      IDLE: begin
        cpu_stall = ram_access;
        if (mmio_load) begin
          cpu_rdata = mmio_rdata;
        end
      end
      REQ: begin
        cpu_stall = 1'b1;
      end
      DONE: begin
        if (!mem_we) begin
          cpu_rdata = rdata_q;
        end
      end
      default: begin
        cpu_stall = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed self-checking bench for dmem_ctrl with hand-computed expectations.
module tb_dmem_ctrl;

  logic        clk;
  logic        reset;
  logic        cpu_mem_rd;
  logic        cpu_mem_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] debug_out;
  logic        debug_valid;
  logic        align_err;
  logic        bus_err;

  int checksTotal  = 0;
  int checksPassed = 0;

  dmem_ctrl #(
    .TIMEOUT   (8),
    .MMIO_BASE (32'hFFFF0000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cpu_mem_rd  (cpu_mem_rd),
    .cpu_mem_we  (cpu_mem_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_stall   (cpu_stall),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .debug_out   (debug_out),
    .debug_valid (debug_valid),
    .align_err   (align_err),
    .bus_err     (bus_err)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the bench can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checksTotal++;
    if (actual !== expected) begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end else begin
      checksPassed++;
    end
  endtask

  // Present one CPU access, answer mem_req with an ack in REQ cycle ackAt
  // (0 = never), hold strobes until the stall releases, then step past that edge.
  task automatic applyStimulus(input logic rd, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input int ackAt, input logic [31:0] ackData,
                               output int stalls, output int reqCycles,
                               output logic [31:0] rdata, output logic released);
    cpu_mem_rd = rd;
    cpu_mem_we = we;
    cpu_addr   = addr;
    cpu_wdata  = wdata;
    stalls     = 0;
    reqCycles  = 0;
    rdata      = '0;
    released   = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (mem_req) begin
        reqCycles++;
        mem_ack   = (reqCycles == ackAt);
        mem_rdata = ackData;
      end else begin
        mem_ack = 1'b0;
      end
      #1;
      if (!cpu_stall) begin
        rdata    = cpu_rdata;
        released = 1'b1;
        break;
      end
      stalls++;
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    cpu_mem_rd = 1'b0;
    cpu_mem_we = 1'b0;
    mem_ack    = 1'b0;
    mem_rdata  = '0;
  endtask

  initial begin
    int          stalls;
    int          reqCycles;
    logic [31:0] rdata;
    logic        released;
    logic [31:0] cnt1;
    logic [31:0] cnt2;

    reset      = 1'b1;
    cpu_mem_rd = 1'b0;
    cpu_mem_we = 1'b0;
    cpu_addr   = '0;
    cpu_wdata  = '0;
    mem_ack    = 1'b0;
    mem_rdata  = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;

    checkOutput("rst_mem_req",   32'(mem_req),   32'd0);
    checkOutput("rst_mem_addr",  mem_addr,       32'd0);
    checkOutput("rst_debug_out", debug_out,      32'd0);
    checkOutput("rst_align_err", 32'(align_err), 32'd0);
    checkOutput("rst_bus_err",   32'(bus_err),   32'd0);
    checkOutput("rst_stall",     32'(cpu_stall), 32'd0);

    // Load with ack one cycle after mem_req rises
    applyStimulus(1'b1, 1'b0, 32'h0000_0100, 32'h0, 2, 32'h1234_5678, stalls, reqCycles, rdata, released);
    checkOutput("ld_released", 32'(released), 32'd1);
    checkOutput("ld_stalls",   32'(stalls),   32'd3);
    checkOutput("ld_rdata",    rdata,         32'h1234_5678);
    checkOutput("ld_mem_addr", mem_addr,      32'h0000_0100);
    checkOutput("ld_mem_we",   32'(mem_we),   32'd0);
    checkOutput("ld_req_low",  32'(mem_req),  32'd0);

    // Store with ack in the first REQ cycle
    applyStimulus(1'b0, 1'b1, 32'h0000_0000, 32'hCAFE_F00D, 1, 32'hFFFF_FFFF, stalls, reqCycles, rdata, released);
    checkOutput("st_stalls",    32'(stalls), 32'd2);
    checkOutput("st_mem_we",    32'(mem_we), 32'd1);
    checkOutput("st_mem_wdata", mem_wdata,   32'hCAFE_F00D);
    checkOutput("st_rdata",     rdata,       32'd0);

    // Load that is never acknowledged times out after 8 REQ cycles
    applyStimulus(1'b1, 1'b0, 32'h0000_0040, 32'h0, 0, 32'h0, stalls, reqCycles, rdata, released);
    checkOutput("to_released", 32'(released),  32'd1);
    checkOutput("to_req_cyc",  32'(reqCycles), 32'd8);
    checkOutput("to_stalls",   32'(stalls),    32'd9);
    checkOutput("to_rdata",    rdata,          32'hDEAD_BEEF);
    checkOutput("to_bus_err",  32'(bus_err),   32'd1);

    // Simultaneous rd and we is a store; bus_err stays sticky
    applyStimulus(1'b1, 1'b1, 32'h0000_0200, 32'h5555_AAAA, 1, 32'h0, stalls, reqCycles, rdata, released);
    checkOutput("rw_mem_we",   32'(mem_we),  32'd1);
    checkOutput("rw_rdata",    rdata,        32'd0);
    checkOutput("rw_bus_err",  32'(bus_err), 32'd1);

    // MMIO debug write: no stall, one valid pulse
    applyStimulus(1'b0, 1'b1, 32'hFFFF_0004, 32'd7, 0, 32'h0, stalls, reqCycles, rdata, released);
    checkOutput("dbg_stalls",  32'(stalls),      32'd0);
    checkOutput("dbg_no_req",  32'(reqCycles),   32'd0);
    checkOutput("dbg_out",     debug_out,        32'd7);
    checkOutput("dbg_valid1",  32'(debug_valid), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("dbg_valid0",  32'(debug_valid), 32'd0);

    // MMIO reads: debug register, unmapped offset, counter delta over 10 cycles
    applyStimulus(1'b1, 1'b0, 32'hFFFF_0004, 32'h0, 0, 32'h0, stalls, reqCycles, rdata, released);
    checkOutput("rd_dbg",      rdata,        32'd7);
    applyStimulus(1'b1, 1'b0, 32'hFFFF_0008, 32'h0, 0, 32'h0, stalls, reqCycles, rdata, released);
    checkOutput("rd_unmapped", rdata,        32'd0);
    applyStimulus(1'b1, 1'b0, 32'hFFFF_0000, 32'h0, 0, 32'h0, stalls, reqCycles, cnt1, released);
    repeat (9) @(posedge clk);
    #1;
    applyStimulus(1'b1, 1'b0, 32'hFFFF_0000, 32'h0, 0, 32'h0, stalls, reqCycles, cnt2, released);
    checkOutput("cnt_stalls",  32'(stalls),  32'd0);
    checkOutput("cnt_delta",   cnt2 - cnt1,  32'd10);

    // Misaligned load: no stall, no request, zero data, sticky align_err
    checkOutput("pre_align",   32'(align_err), 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h0000_0102, 32'h0, 1, 32'h1111_1111, stalls, reqCycles, rdata, released);
    checkOutput("mis_stalls",  32'(stalls),    32'd0);
    checkOutput("mis_no_req",  32'(reqCycles), 32'd0);
    checkOutput("mis_rdata",   rdata,          32'd0);
    checkOutput("mis_align",   32'(align_err), 32'd1);

    // Reset during REQ drops mem_req at once, then a fresh load completes
    cpu_mem_rd = 1'b1;
    cpu_addr   = 32'h0000_0300;
    @(posedge clk);
    #1;
    checkOutput("mr_req_high", 32'(mem_req), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("mr_req_drop", 32'(mem_req),   32'd0);
    checkOutput("mr_bus_clr",  32'(bus_err),   32'd0);
    checkOutput("mr_aln_clr",  32'(align_err), 32'd0);
    cpu_mem_rd = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 1'b0, 32'h0000_0304, 32'h0, 1, 32'hA5A5_A5A5, stalls, reqCycles, rdata, released);
    checkOutput("mr_stalls",   32'(stalls),  32'd2);
    checkOutput("mr_rdata",    rdata,        32'hA5A5_A5A5);
    checkOutput("mr_mem_addr", mem_addr,     32'h0000_0304);

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
